// File: rtl/imem_pkg.sv
// Shared constants and the address validity check used by the fetch and load paths
// of the instruction store.
package imem_pkg;
    localparam int          WORD_W        = 32;
    localparam int          DEFAULT_DEPTH = 256;
    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;

    // A byte address is usable only when word-aligned and inside the store; no wrap.
    function automatic logic addr_ok(input logic [31:0] addr, input int depth);
        return (addr[1:0] == 2'b00) && (addr < (32'(depth) << 2));
    endfunction
endpackage

// File: rtl/instruction_memory.sv
// Word-organised instruction store: combinational fetch by byte PC, synchronous
// program-load port, asynchronous clear of every word to NOP_WORD.
module instruction_memory #(
    parameter int          DEPTH    = imem_pkg::DEFAULT_DEPTH,
    parameter int          ADDR_W   = $clog2(DEPTH),
    parameter logic [31:0] NOP_WORD = imem_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PC,
    output logic [31:0] instruction,
    output logic        fetch_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        load_err
);
    import imem_pkg::*;

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic              r_load_err;

    logic              w_fetch_ok;
    logic [ADDR_W-1:0] w_fetch_idx;
    logic              w_load_ok;
    logic [ADDR_W-1:0] w_load_idx;
    logic              w_load_wr;

    assign w_fetch_ok  = addr_ok(PC, DEPTH);
    assign w_fetch_idx = PC[ADDR_W+1:2];
    assign w_load_ok   = addr_ok(load_addr, DEPTH);
    assign w_load_idx  = load_addr[ADDR_W+1:2];
    assign w_load_wr   = load_en && w_load_ok;

    // Reset holds the output at NOP so nothing undefined reaches decode.
    assign instruction = (rst_n && w_fetch_ok) ? r_mem[w_fetch_idx] : NOP_WORD;
    assign fetch_err   = !w_fetch_ok;
    assign load_err    = r_load_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= NOP_WORD;
            end
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= load_en && !w_load_ok;
            if (w_load_wr) begin
                r_mem[w_load_idx] <= load_data;
            end
        end
    end
endmodule

// File: tb/tb_instruction_memory.sv
// Randomised and directed checks of instruction_memory against an array-based model.
module tb_instruction_memory;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] PC = 32'h0;
    logic [31:0] instruction;
    logic        fetch_err;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = 32'h0;
    logic [31:0] load_data = 32'h0;
    logic        load_err;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_mem [DEPTH];
    logic        m_load_err = 1'b0;

    instruction_memory #(.DEPTH(DEPTH), .ADDR_W(8), .NOP_WORD(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .PC(PC), .instruction(instruction),
        .fetch_err(fetch_err), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .load_err(load_err)
    );

    always #5 clk = ~clk;

    function automatic bit valid_addr(input logic [31:0] a);
        return (a % 4 == 0) && (a < 4 * DEPTH);
    endfunction

    function automatic logic [31:0] exp_instr();
        if (!rst_n || !valid_addr(PC)) return 32'h0;
        return m_mem[PC / 4];
    endfunction

    // Reference model: a plain array written by load requests, wiped by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
            m_load_err = 1'b0;
        end else begin
            m_load_err = load_en && !valid_addr(load_addr);
            if (load_en && valid_addr(load_addr)) m_mem[load_addr / 4] = load_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if ($isunknown(act) || act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_instruction", instruction, exp_instr());
            chk("cyc_fetch_err", {31'b0, fetch_err}, {31'b0, !valid_addr(PC)});
            chk("cyc_load_err", {31'b0, load_err}, {31'b0, m_load_err});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic set_pc(input logic [31:0] p);
        PC = p;
        #1;
    endtask

    initial begin
        #12;
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // Reset clears a loaded word
        do_load(32'h0, 32'hDEAD_BEEF);
        set_pc(32'h0);
        chk("pre_reset_word", instruction, 32'hDEAD_BEEF);
        rst_n = 1'b0; #2;
        chk("during_reset_nop", instruction, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("reset_cleared", instruction, 32'h0);
        chk("reset_fetch_err", {31'b0, fetch_err}, 32'h0);

        // Load and fetch sequence
        do_load(32'h0, 32'h2002_0005);
        do_load(32'h4, 32'h0022_1820);
        do_load(32'h8, 32'hAC03_0008);
        set_pc(32'h0); chk("fetch_0", instruction, 32'h2002_0005);
        set_pc(32'h4); chk("fetch_4", instruction, 32'h0022_1820);
        set_pc(32'h8); chk("fetch_8", instruction, 32'hAC03_0008);
        set_pc(32'hC); chk("fetch_C", instruction, 32'h0);

        // Misaligned / out-of-range
        set_pc(32'h6);
        chk("misalign_instr", instruction, 32'h0);
        chk("misalign_err", {31'b0, fetch_err}, 32'h1);
        set_pc(32'h400);
        chk("oor_instr", instruction, 32'h0);
        chk("oor_err", {31'b0, fetch_err}, 32'h1);
        do_load(32'h3FC, 32'hCAFE_F00D);
        set_pc(32'h3FC);
        chk("last_word", instruction, 32'hCAFE_F00D);
        chk("last_word_err", {31'b0, fetch_err}, 32'h0);

        // Rejected load
        do_load(32'h402, 32'hBAD0_BAD0);
        chk("rej_load_err", {31'b0, load_err}, 32'h1);
        tick();
        chk("rej_load_err_clear", {31'b0, load_err}, 32'h0);
        set_pc(32'h0);
        chk("rej_word0_kept", instruction, 32'h2002_0005);

        // Read-during-write
        do_load(32'h10, 32'h1111_1111);
        set_pc(32'h10);
        load_en = 1'b1; load_addr = 32'h10; load_data = 32'h2222_2222;
        #2;
        chk("rdw_before_edge", instruction, 32'h1111_1111);
        tick();
        load_en = 1'b0;
        chk("rdw_after_edge", instruction, 32'h2222_2222);

        // Reset priority over load
        rst_n = 1'b0;
        load_en = 1'b1; load_addr = 32'h14; load_data = 32'h3333_3333;
        tick();
        load_en = 1'b0;
        rst_n = 1'b1;
        tick();
        set_pc(32'h14);
        chk("reset_priority", instruction, 32'h0);
        set_pc(32'h10);
        chk("reset_lost_contents", instruction, 32'h0);

        // Randomised traffic, checked every cycle by the compare process
        for (int n = 0; n < 600; n++) begin
            load_en = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 7))
                0: load_addr = $urandom;
                1: load_addr = ($urandom_range(0, DEPTH - 1) * 4) | $urandom_range(1, 3);
                default: load_addr = $urandom_range(0, DEPTH - 1) * 4;
            endcase
            load_data = $urandom;
            case ($urandom_range(0, 7))
                0: PC = $urandom;
                1: PC = 32'h400 + $urandom_range(0, 15) * 4;
                2: PC = load_addr;
                default: PC = $urandom_range(0, DEPTH - 1) * 4;
            endcase
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0; #2; rst_n = 1'b1;
            end
            tick();
        end
        load_en = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instruction_memory.md
Name: instruction_memory

Overview:
- Word-organised instruction store for the single-cycle/pipelined processor's fetch stage.
- The fetch stage drives the byte-addressed PC; the block returns the 32-bit instruction combinationally, within the same cycle, with no clock latency.
- A synchronous load port fills the store before or between runs.
- Reset clears every word to NOP (32'h0000_0000).

Parameters:
- DEPTH, 256, number of 32-bit instruction words (power of two, 4..1024).
- ADDR_W, 8, word-index width; must equal log2(DEPTH).
- NOP_WORD, 32'h0000_0000, value returned for invalid fetches and stored on reset.

Ports:
- clk  input  1  rising-edge clock for load writes.
- rst_n  input  1  asynchronous active-low reset.
- PC  input  32  byte address of the instruction to fetch.
- instruction  output  32  instruction word at PC.
- fetch_err  output  1  high when PC is misaligned or out of range.
- load_en  input  1  write strobe for the program-load port.
- load_addr  input  32  byte address of the word to load.
- load_data  input  32  instruction word to load.
- load_err  output  1  registered; high for one cycle after a rejected load.

Behaviour:
- Storage: DEPTH x 32 register array, word index = address[ADDR_W+1:2].
- Reset (rst_n low, asynchronous):
  - all words become NOP_WORD; load_err clears to 0.
  - instruction reads NOP_WORD while reset is held.
  - fetch_err still reflects PC alignment and range during reset.
- Read path, purely combinational:
  - instruction = mem[PC[ADDR_W+1:2]] when PC[1:0]==0 and PC < 4*DEPTH.
  - otherwise instruction = NOP_WORD and fetch_err = 1.
  - a PC change propagates to instruction within the same cycle (combinational delay only).
- Valid PC range: 0 .. 4*DEPTH-4. Addresses ≥ 4*DEPTH do not wrap; they are out of range.
- Load path:
  - on posedge clk with load_en=1, load_addr[1:0]==0 and load_addr < 4*DEPTH: write load_data to mem[load_addr[ADDR_W+1:2]], and load_err <= 0.
  - invalid load address: no write, and load_err <= 1 for that cycle.
  - load_en=0: no write, and load_err <= 0.
- Read-during-write to the same word: instruction shows the old word until the clock edge, then the new word (write-first after the edge, no bypass).
- Simultaneous reset and load_en: reset wins; no write occurs.
- Reset asserted mid-run: contents are lost; the program must be reloaded.
- No X propagation: instruction must never be X once reset has been applied.

Decomposition:
- Shared package imem_pkg holds:
  - NOP_WORD
  - WORD_W = 32
  - the default DEPTH
  - a function addr_ok(addr, depth) for the alignment and range check, used by both the read and load paths.
- No sub-module is needed. An optional leaf imem_addr_check (combinational valid flag plus word index) is acceptable if it is instantiated twice, once for PC and once for load_addr.

Test Plan:
- Reset clears: load 32'hDEAD_BEEF at address 0x0, pulse rst_n low, set PC=0x0 -> instruction=32'h0000_0000, fetch_err=0.
- Load and fetch sequence:
  - load 32'h2002_0005 @0x0, 32'h0022_1820 @0x4, 32'hAC03_0008 @0x8.
  - step PC 0,4,8 -> the same words appear combinationally within each cycle.
  - set PC=0xC -> instruction=0.
- Misaligned/out-of-range fetch (DEPTH=256):
  - PC=0x6 -> instruction=0, fetch_err=1.
  - PC=0x400 -> instruction=0, fetch_err=1.
  - PC=0x3FC -> the valid last word, fetch_err=0.
- Rejected load:
  - load_en with load_addr=0x402 -> load_err=1 for one cycle; no word changes.
  - a read of 0x0 still returns its prior value.
- Read-during-write: PC=0x10 holding 32'h1111_1111; load 32'h2222_2222 @0x10 -> instruction=32'h1111_1111 before the edge and 32'h2222_2222 after it.
- Reset priority: assert rst_n low together with load_en (0x14, 32'h3333_3333) -> after release, word 0x14 reads 0.
